// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, sequencer states
// and the index-width helper.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Combinational 4-bit carry-lookahead adder slice.
module four_bit_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Every carry is flattened from generate/propagate, with no ripple between bits.
    assign w_c[0] = Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & Cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & Cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

    assign S    = w_p ^ w_c[3:0];
    assign Cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built by time-multiplexing one four_bit_adder slice, LSB nibble first,
// with valid/ready handshakes on both the operand side and the result side.
module nibble_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a_in,
    input  logic [NIBBLE_W*NIBBLES-1:0] b_in,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int                IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                             r_state;
    logic [IDX_W-1:0]                   r_idx;
    logic                               r_carry;
    logic                               r_in_ready;
    logic                               r_out_valid;
    logic                               r_cout;
    logic                               r_ovf;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_b;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   r_sum;

    logic [NIBBLE_W-1:0]                w_a_nib;
    logic [NIBBLE_W-1:0]                w_b_nib;
    logic [NIBBLE_W-1:0]                w_s;
    logic                               w_cout;
    logic                               w_carry_msb;

    assign w_a_nib = r_a[r_idx];
    assign w_b_nib = r_b[r_idx];

    four_bit_adder u_slice (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    // Carry into the top bit, recovered from that bit's inputs and its sum output.
    assign w_carry_msb = w_a_nib[NIBBLE_W-1] ^ w_b_nib[NIBBLE_W-1] ^ w_s[NIBBLE_W-1];

    // NOTE: operand registers carry no reset; they are only consumed after an
    // accept edge has loaded them, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        if (!rst && r_state == IDLE && in_valid) begin
            r_a <= a_in;
            r_b <= b_in;
        end
    end

    // NOTE: every register update here is non-blocking so all state moves
    // together on the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_carry    <= cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= w_s;
                    r_carry      <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout      <= w_cout;
                        r_ovf       <= w_carry_msb ^ w_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: drivers push expected results into queues, monitors pop
// and compare whenever a result is handed over. Covers NIBBLES=4 and NIBBLES=2.
module tb_nibble_serial_adder_ctrl;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    // NIBBLES=4 instance
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [15:0] a_in, b_in, sum;
    // NIBBLES=2 instance
    logic        in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, ovf2;
    logic [7:0]  a_in2, b_in2, sum2;

    exp_t q4[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_in(a_in2), .b_in(b_in2), .cin(cin2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: true sum of the low w bits; overflow by the sign rule.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c, input int w);
        logic [16:0] full;
        logic [15:0] mask;
        exp_t        e;
        mask   = 16'((32'd1 << w) - 1);
        full   = {1'b0, a & mask} + {1'b0, b & mask} + 17'(c);
        e.sum  = full[15:0] & mask;
        e.cout = full[w];
        e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        return e;
    endfunction

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                check("mon4_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                check("mon4_sum", 32'(sum), 32'(e.sum));
                check("mon4_cout", 32'(cout), 32'(e.cout));
                check("mon4_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (!rst && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                check("mon2_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("mon2_sum", 32'(sum2), 32'(e.sum[7:0]));
                check("mon2_cout", 32'(cout2), 32'(e.cout));
                check("mon2_ovf", 32'(ovf2), 32'(e.ovf));
            end
        end
    end

    // All driver tasks start and end #1 after a rising edge.
    task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input exp_t e, input bit keep_valid, output int acc_cyc);
        int n = 0;
        a_in = a; b_in = b; cin = c; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("send4_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        q4.push_back(e);
        acc_cyc = cyc;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_out4(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) check("wait_out4_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle4;
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("wait_idle4_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   lat, acc, prev, n;
        bit   ghost;
        exp_t e;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'h000D, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; a_in2 = '0; b_in2 = '0; cin2 = 1'b0; out_ready2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset2_in_ready", 32'(in_ready2), 32'd1);
        check("reset2_out_valid", 32'(out_valid2), 32'd0);
        check("reset2_sum", 32'(sum2), 32'd0);

        // Directed vectors with hand-computed results, checking latency each time.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            e = '{sum: vecs[i].s, cout: vecs[i].co, ovf: vecs[i].ov};
            send4(vecs[i].a, vecs[i].b, vecs[i].c, e, 1'b0, acc);
            wait_out4(lat);
            check("latency", 32'(lat), 32'd4);
            wait_idle4();
        end

        // Backpressure: result must hold while new operands are offered.
        out_ready = 1'b0;
        send4(16'h1234, 16'h1111, 1'b0, '{sum: 16'h2345, cout: 1'b0, ovf: 1'b0}, 1'b0, acc);
        wait_out4(lat);
        for (int k = 0; k < 6; k++) begin
            in_valid = k[0];
            a_in = 16'hAAAA; b_in = 16'h5555; cin = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'h2345);
            check("bp_cout", 32'(cout), 32'd0);
            check("bp_ovf", 32'(ovf), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1 check("bp_no_ghost_accept", 32'(in_ready), 32'd1);

        // Reset while the third nibble is being processed.
        send4(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0, 16), 1'b0, acc);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(q4.pop_back());
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        check("midrun_rst_sum", 32'(sum), 32'd0);
        ghost = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            ghost = ghost | out_valid;
        end
        check("midrun_rst_no_pulse", 32'(ghost), 32'd0);
        send4(16'h00FF, 16'h0001, 1'b0, '{sum: 16'h0100, cout: 1'b0, ovf: 1'b0}, 1'b0, acc);
        wait_out4(lat);
        wait_idle4();

        // Back-to-back random stream, NIBBLES=4: one accept every 6 cycles.
        prev = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra, rb;
            logic        rc;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            send4(ra, rb, rc, model(ra, rb, rc, 16), 1'b1, acc);
            if (i > 0) check("b2b4_interval", 32'(acc - prev), 32'd6);
            prev = acc;
        end
        in_valid = 1'b0;

        // Back-to-back random stream, NIBBLES=2: one accept every 4 cycles.
        out_ready2 = 1'b1;
        in_valid2  = 1'b1;
        prev = 0;
        for (int i = 0; i < 1000; i++) begin
            a_in2 = 8'($urandom); b_in2 = 8'($urandom); cin2 = 1'($urandom);
            n = 0;
            while (!in_ready2 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            if (!in_ready2) check("send2_ready_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            q2.push_back(model({8'h00, a_in2}, {8'h00, b_in2}, cin2, 8));
            if (i > 0) check("b2b2_interval", 32'(cyc - prev), 32'd4);
            prev = cyc;
        end
        in_valid2 = 1'b0;

        n = 0;
        while ((q4.size() != 0 || q2.size() != 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("scoreboard_drained", 32'(q4.size() + q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
